// File: rtl/multi_string_matcher_if.sv
// Stream, result and configuration signals of the multi-string matcher.
// The master side drives config and input words; the slave side is the matcher.
interface multi_string_matcher_if #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned NUM_PAT = 4
);
  localparam int unsigned PW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic                 cfg_we;
  logic                 cfg_len_we;
  logic [PW-1:0]        cfg_sel;
  logic [AW-1:0]        cfg_addr;
  logic [7:0]           cfg_data;
  logic                 cfg_busy;
  logic                 in_valid;
  logic [8*LANES-1:0]   in_data;
  logic                 in_last;
  logic                 out_valid;
  logic [8*LANES-1:0]   out_data;
  logic [NUM_PAT-1:0]   match_vec;
  logic                 pkt_done;
  logic [NUM_PAT-1:0]   pkt_hits;

  modport master (
    output cfg_we, cfg_len_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_data, in_last,
    input  cfg_busy, out_valid, out_data, match_vec, pkt_done, pkt_hits
  );

  modport slave (
    input  cfg_we, cfg_len_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_data, in_last,
    output cfg_busy, out_valid, out_data, match_vec, pkt_done, pkt_hits
  );
endinterface

// File: rtl/multi_string_matcher.sv
// Streaming multi-pattern byte matcher: finds up to NUM_PAT strings at any byte alignment.
// Define CASE_FOLD_EN to fold ASCII upper case to lower case before comparison.
module multi_string_matcher #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned NUM_PAT = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  multi_string_matcher_if.slave bus
);
  localparam int unsigned PW      = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int unsigned HIST    = MAX_LEN + LANES - 1;
  localparam int unsigned TOT     = HIST + LANES;
  localparam int unsigned CNT_MAX = MAX_LEN + LANES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e               state_q, state_d;
  logic [7:0]           hist_q [HIST];
  logic [7:0]           hist_d [HIST];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_PAT-1:0]   acc_q, acc_d;
  logic [7:0]           pat_q [NUM_PAT][MAX_LEN];
  logic [LW-1:0]        len_q [NUM_PAT];
  logic                 out_valid_q, out_valid_d;
  logic [8*LANES-1:0]   out_data_q, out_data_d;
  logic [NUM_PAT-1:0]   match_vec_q, match_vec_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [NUM_PAT-1:0]   pkt_hits_q, pkt_hits_d;

  logic [7:0]           all_b [TOT];
  logic [NUM_PAT-1:0]   mv;
  logic                 cfg_ok;
  logic [LW-1:0]        len_in, len_sat;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef CASE_FOLD_EN
    fold = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
    fold = b;
`endif
  endfunction

  // Stream order: all_b[0] oldest history byte, all_b[TOT-1] last lane of the new word.
  always_comb begin
    for (int i = 0; i < int'(HIST); i++) all_b[i] = hist_q[i];
    for (int j = 0; j < int'(LANES); j++) all_b[int'(HIST) + j] = bus.in_data[8*(int'(LANES)-j)-1 -: 8];
  end

  // Candidate ending at lane k compares pattern byte len-1-d against the byte d places back.
  always_comb begin
    logic          hit;
    logic [AW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    mv  = '0;
    for (int p = 0; p < int'(NUM_PAT); p++) begin
      for (int k = 0; k < int'(LANES); k++) begin
        hit = (len_q[p] != '0) && (32'(cnt_q) + 32'(k) + 32'd1 >= 32'(len_q[p]));
        for (int d = 0; d < int'(MAX_LEN); d++) begin
          if (d < int'(len_q[p])) begin
            idx = AW'(int'(len_q[p]) - 1 - d);
            if (fold(all_b[int'(HIST) + k - d]) != fold(pat_q[p][idx])) hit = 1'b0;
          end
        end
        mv[p] = mv[p] | hit;
      end
    end
  end

  assign cfg_ok  = (state_q != StScan) && (32'(bus.cfg_sel) < NUM_PAT);
  assign len_in  = bus.cfg_data[LW-1:0];
  assign len_sat = (32'(len_in) > MAX_LEN) ? LW'(MAX_LEN) : len_in;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pat_q <= '{default: '{default: '0}};
      len_q <= '{default: '0};
    end else begin
      if (cfg_ok && bus.cfg_we)     pat_q[bus.cfg_sel][bus.cfg_addr] <= bus.cfg_data;
      if (cfg_ok && bus.cfg_len_we) len_q[bus.cfg_sel] <= len_sat;
    end
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    match_vec_d = '0;
    pkt_done_d  = 1'b0;
    pkt_hits_d  = '0;
    if (clear) begin
      state_d    = StIdle;
      hist_d     = '{default: '0};
      cnt_d      = '0;
      acc_d      = '0;
      out_data_d = '0;
    end else if (bus.in_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data;
      match_vec_d = mv;
      if (bus.in_last) begin
        pkt_done_d = 1'b1;
        pkt_hits_d = acc_q | mv;
        acc_d      = '0;
        hist_d     = '{default: '0};
        cnt_d      = '0;
        state_d    = StIdle;
      end else begin
        acc_d = acc_q | mv;
        for (int i = 0; i < int'(HIST); i++) hist_d[i] = all_b[i + int'(LANES)];
        if (32'(cnt_q) + LANES >= CNT_MAX) cnt_d = CW'(CNT_MAX);
        else                               cnt_d = cnt_q + CW'(LANES);
        state_d = StScan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      hist_q      <= '{default: '0};
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      match_vec_q <= '0;
      pkt_done_q  <= 1'b0;
      pkt_hits_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      match_vec_q <= match_vec_d;
      pkt_done_q  <= pkt_done_d;
      pkt_hits_q  <= pkt_hits_d;
    end
  end

  assign bus.cfg_busy  = (state_q == StScan);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.match_vec = match_vec_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.pkt_hits  = pkt_hits_q;
endmodule

// File: tb/tb_multi_string_matcher.sv
// Scoreboard bench for multi_string_matcher: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_multi_string_matcher;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mv;
    logic        done;
    logic [3:0]  hits;
  } exp_t;
  exp_t q[$];

  multi_string_matcher_if bus ();

  multi_string_matcher dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] w4(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic cfg_pat(input int sel, input string s);
    bus.cfg_sel = 2'(sel);
    for (int i = 0; i < s.len(); i++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'(i);
      bus.cfg_data = s[i];
      tick();
    end
    bus.cfg_we     = 1'b0;
    bus.cfg_len_we = 1'b1;
    bus.cfg_data   = 8'(s.len());
    tick();
    bus.cfg_len_we = 1'b0;
  endtask

  task automatic send(input string s, input logic last, input logic [3:0] mv,
                      input logic [3:0] hits);
    exp_t e;
    e.data = w4(s);
    e.mv   = mv;
    e.done = last;
    e.hits = last ? hits : 4'h0;
    q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = w4(s);
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid actual=1 expected=0 data=%h", bus.out_data);
        end else begin
          e = q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("match_vec", 32'(bus.match_vec), 32'(e.mv));
          check("pkt_done", 32'(bus.pkt_done), 32'(e.done));
          if (e.done) check("pkt_hits", 32'(bus.pkt_hits), 32'(e.hits));
        end
      end else if (bus.pkt_done || bus.match_vec != 4'h0) begin
        check("idle_outputs", {27'h0, bus.pkt_done, bus.match_vec}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_len_we = 1'b0; bus.cfg_sel = '0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_match_vec", 32'(bus.match_vec), 32'h0);
    check("rst_pkt_done", 32'(bus.pkt_done), 32'h0);
    check("rst_pkt_hits", 32'(bus.pkt_hits), 32'h0);
    check("rst_cfg_busy", 32'(bus.cfg_busy), 32'h0);
    n_rst = 1'b1;
    tick();

    cfg_pat(0, "ab");
    send("zzab", 1'b1, 4'b0001, 4'b0001);
    check("busy_after_single", 32'(bus.cfg_busy), 32'h0);

    // "ETH" at every offset, including one packet with an idle gap mid-match
    cfg_pat(0, "ETH");
    send("ETHx", 1'b1, 4'b0001, 4'b0001);
    send("xETH", 1'b1, 4'b0001, 4'b0001);
    send("xxET", 1'b0, 4'b0000, 4'b0000);
    tick();
    send("Hyyy", 1'b1, 4'b0001, 4'b0001);
    send("xxxE", 1'b0, 4'b0000, 4'b0000);
    send("THyy", 1'b1, 4'b0001, 4'b0001);

    cfg_pat(1, "0123456789ABCDEF");
    cfg_pat(2, "9A");
    send("x012", 1'b0, 4'b0000, 4'b0000);
    send("3456", 1'b0, 4'b0000, 4'b0000);
    send("789A", 1'b0, 4'b0100, 4'b0000);
    send("BCDE", 1'b0, 4'b0000, 4'b0000);
    send("Fxyz", 1'b1, 4'b0010, 4'b0110);

    cfg_pat(3, "ABCD");
    send("wxyz", 1'b0, 4'b0000, 4'b0000);
    send("xxAB", 1'b1, 4'b0000, 4'b0000);
    send("CDxx", 1'b1, 4'b0000, 4'b0000);
    send("ABCD", 1'b1, 4'b1000, 4'b1000);

    // writes during a packet must not touch pat3 byte 3 or its length
    send("wxyz", 1'b0, 4'b0000, 4'b0000);
    check("busy_in_scan", 32'(bus.cfg_busy), 32'h1);
    bus.cfg_sel = 2'd3; bus.cfg_addr = 4'd3; bus.cfg_data = 8'h05;
    bus.cfg_we = 1'b1; bus.cfg_len_we = 1'b1;
    tick();
    bus.cfg_we = 1'b0; bus.cfg_len_we = 1'b0;
    send("zzzz", 1'b1, 4'b0000, 4'b0000);
    send("ABCD", 1'b1, 4'b1000, 4'b1000);

    // clear drops the partial "AB" and the word presented with it
    send("xxAB", 1'b0, 4'b0000, 4'b0000);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = w4("zzzz");
    tick();
    clear = 1'b0; bus.in_valid = 1'b0;
    check("busy_after_clear", 32'(bus.cfg_busy), 32'h0);
    send("CDxx", 1'b1, 4'b0000, 4'b0000);

    cfg_pat(0, "mac");
`ifdef CASE_FOLD_EN
    send("xMAC", 1'b1, 4'b0001, 4'b0001);
`else
    send("xMAC", 1'b1, 4'b0000, 4'b0000);
`endif
    send("xmac", 1'b1, 4'b0001, 4'b0001);

    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    tick();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_outputs actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
